// File: rtl/jt12_pm_mix.sv
// JT12 phase-modulation mixer: keeps operator-result history and per-channel
// stores, selects/sums modulator operands and registers the 10-bit PM offset.

module jt12_pm_rot #(
  parameter int DEPTH = 6,
  parameter int W     = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic [W-1:0] din,
  output logic [W-1:0] head
);
  logic [DEPTH-1:0][W-1:0] mem;

  always_ff @(posedge clk) begin
    if (rst)         mem <= '0;
    else if (clk_en) mem <= {mem[DEPTH-2:0], din};
  end

  assign head = mem[DEPTH-1];
endmodule

module jt12_pm_mix #(
  parameter int num_ch = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        s1_enters,
  input  logic        s2_enters,
  input  logic        s3_enters,
  input  logic        s4_enters,
  input  logic        xuse_prevprev1,
  input  logic        xuse_prev2,
  input  logic        xuse_internal,
  input  logic        yuse_prev1,
  input  logic        yuse_prev2,
  input  logic        yuse_internal,
  input  logic [2:0]  fb_II,
  input  logic [13:0] op_result,
  input  logic        res_s1,
  input  logic        res_s3,
  output logic [9:0]  pm_II
);
  localparam int HL = 3*num_ch;
  localparam int IX = 0, IY = 1, FB0 = 2, FB1 = 3;

  logic [HL-1:0][13:0] hist;
  logic [3:0][13:0]    rot_din, rot_head;

  logic signed [13:0] prev1, prev2, prevprev1, x, y;
  logic signed [14:0] mod_sum, fb_sum, fb_sh;
  logic [3:0]         fb_amt;
  logic [9:0]         pm_nx;
  logic               unused_bits;

  assign prev1     = hist[num_ch-1];
  assign prev2     = hist[2*num_ch-1];
  assign prevprev1 = hist[3*num_ch-1];

  // Per-channel stores: one rotator each, head is the same channel's value
  // from num_ch slots ago. S1 wins over S3 when both result flags are set.
  assign rot_din[IX]  = res_s1 ? op_result : rot_head[IX];
  assign rot_din[IY]  = (res_s3 && !res_s1) ? op_result : rot_head[IY];
  assign rot_din[FB0] = res_s1 ? op_result : rot_head[FB0];
  assign rot_din[FB1] = res_s1 ? rot_head[FB0] : rot_head[FB1];

  for (genvar g = 0; g < 4; g++) begin : g_rot
    jt12_pm_rot #(.DEPTH(num_ch), .W(14)) u_rot (
      .clk   (clk),
      .rst   (rst),
      .clk_en(clk_en),
      .din   (rot_din[g]),
      .head  (rot_head[g])
    );
  end

  always_comb begin
    x = '0;
    if (xuse_prevprev1)     x = prevprev1;
    else if (xuse_prev2)    x = prev2;
    else if (xuse_internal) x = rot_head[IX];
    y = '0;
    if (yuse_prev1)         y = prev1;
    else if (yuse_prev2)    y = prev2;
    else if (yuse_internal) y = rot_head[IY];
  end

  assign mod_sum = {x[13], x} + {y[13], y};
  assign fb_sum  = {rot_head[FB0][13], rot_head[FB0]} + {rot_head[FB1][13], rot_head[FB1]};
  assign fb_amt  = 4'd10 - {1'b0, fb_II};
  assign fb_sh   = fb_sum >>> fb_amt;

  always_comb begin
    pm_nx = '0;
    if (s1_enters)
      pm_nx = (fb_II == 3'd0) ? 10'd0 : fb_sh[9:0];
    else if (s2_enters || s3_enters || s4_enters)
      pm_nx = mod_sum[10:1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist  <= '0;
      pm_II <= '0;
    end else if (clk_en) begin
      hist  <= {hist[HL-2:0], op_result};
      pm_II <= pm_nx;
    end
  end

  assign unused_bits = ^{mod_sum[14:11], mod_sum[0], fb_sh[14:10]};
endmodule

// File: tb/tb_jt12_pm_mix.sv
// Self-checking bench for jt12_pm_mix: directed literal cases plus random
// traffic against a slot-history model.

module tb_jt12_pm_mix;
  localparam int NC = 6;

  logic clk = 1'b0, rst = 1'b0, clk_en = 1'b0;
  logic s1_enters = 0, s2_enters = 0, s3_enters = 0, s4_enters = 0;
  logic xuse_prevprev1 = 0, xuse_prev2 = 0, xuse_internal = 0;
  logic yuse_prev1 = 0, yuse_prev2 = 0, yuse_internal = 0;
  logic [2:0] fb_II = '0;
  logic signed [13:0] op_result = '0;
  logic res_s1 = 0, res_s3 = 0;
  logic [9:0] pm_II;

  jt12_pm_mix #(.num_ch(NC)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .s1_enters(s1_enters), .s2_enters(s2_enters), .s3_enters(s3_enters), .s4_enters(s4_enters),
    .xuse_prevprev1(xuse_prevprev1), .xuse_prev2(xuse_prev2), .xuse_internal(xuse_internal),
    .yuse_prev1(yuse_prev1), .yuse_prev2(yuse_prev2), .yuse_internal(yuse_internal),
    .fb_II(fb_II), .op_result(op_result), .res_s1(res_s1), .res_s3(res_s3),
    .pm_II(pm_II)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every enabled slot since reset, as plain records
  typedef struct { int op; bit s1; bit s3; } ent_t;
  ent_t hq[$];
  logic [9:0] exp_pm = '0;
  bit started = 0;

  function automatic int op_at(int back);
    int n = hq.size();
    if (n - back < 0) return 0;
    return hq[n-back].op;
  endfunction

  // Most recent (skip=0) or earlier same-channel result of the given kind
  function automatic int last_ch(bit want_s1, int skip);
    int k = skip;
    for (int m = hq.size() - NC; m >= 0; m -= NC) begin
      if (want_s1 ? hq[m].s1 : (hq[m].s3 && !hq[m].s1)) begin
        if (k == 0) return hq[m].op;
        k--;
      end
    end
    return 0;
  endfunction

  function automatic logic [9:0] model_pm();
    int x, y, r;
    r = 0;
    if (s1_enters) begin
      if (fb_II != 0) r = (last_ch(1, 0) + last_ch(1, 1)) >>> (10 - int'(fb_II));
    end else if (s2_enters || s3_enters || s4_enters) begin
      x = xuse_prevprev1 ? op_at(3*NC) : xuse_prev2 ? op_at(2*NC) : xuse_internal ? last_ch(1, 0) : 0;
      y = yuse_prev1 ? op_at(NC) : yuse_prev2 ? op_at(2*NC) : yuse_internal ? last_ch(0, 0) : 0;
      r = (x + y) >>> 1;
    end
    return r[9:0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      hq.delete();
      exp_pm = '0;
      started = 1;
    end else if (clk_en) begin
      ent_t e;
      exp_pm = model_pm();
      e.op = int'(op_result); e.s1 = res_s1; e.s3 = res_s3;
      hq.push_back(e);
    end
  end

  always @(negedge clk) if (started) check("model_pm", pm_II, exp_pm);

  // One slot: sl = {s4,s3,s2,s1}, xf = {pp1,p2,int}, yf = {p1,p2,int}
  task automatic cyc(input bit en, input logic signed [13:0] op, input bit r1, input bit r3,
                     input logic [3:0] sl, input logic [2:0] xf, input logic [2:0] yf,
                     input logic [2:0] fb);
    clk_en = en; op_result = op; res_s1 = r1; res_s3 = r3;
    {s4_enters, s3_enters, s2_enters, s1_enters} = sl;
    {xuse_prevprev1, xuse_prev2, xuse_internal} = xf;
    {yuse_prev1, yuse_prev2, yuse_internal} = yf;
    fb_II = fb;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 4'b0, 3'b0, 3'b0, 3'd0);
  endtask

  task automatic do_reset();
    rst = 1; clk_en = 0;
    @(negedge clk);
    rst = 0;
  endtask

  function automatic logic [2:0] pick_flags();
    case ($urandom_range(0, 5))
      0: return 3'b000;
      1: return 3'b100;
      2: return 3'b010;
      3: return 3'b001;
      default: return 3'($urandom);
    endcase
  endfunction

  initial begin
    @(negedge clk);
    do_reset();
    check("reset_pm", pm_II, 10'd0);

    // Reset discards a populated history
    for (int i = 0; i < 3*NC; i++)
      cyc(1, 14'($urandom) | 14'd1, 1, 1, 4'b0, 3'b0, 3'b0, 3'd0);
    cyc(1, 14'd0, 0, 0, 4'b0001, 3'b0, 3'b0, 3'd7);
    do_reset();
    check("reset_mid", pm_II, 10'd0);
    for (int i = 0; i < 3*NC; i++) begin
      cyc(1, 0, 0, 0, (i % 2 == 0) ? 4'b0010 : 4'b0001, 3'b101, 3'b101, 3'd7);
      check("post_reset_zero", pm_II, 10'd0);
    end

    // Pure delay taps with a stall in the middle
    do_reset();
    cyc(1, 14'sd100, 0, 0, 4'b0, 3'b0, 3'b0, 3'd0);
    idle(5);
    cyc(1, 0, 0, 0, 4'b0010, 3'b000, 3'b100, 3'd0);
    check("delay_prev1", pm_II, 10'd50);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 14'($urandom), $urandom_range(0, 1), $urandom_range(0, 1), 4'b0100, 3'b100, 3'b100, 3'd7);
      check("stall_hold", pm_II, 10'd50);
    end
    idle(5);
    cyc(1, 0, 0, 0, 4'b0100, 3'b010, 3'b000, 3'd0);
    check("delay_prev2", pm_II, 10'd50);
    idle(5);
    cyc(1, 0, 0, 0, 4'b0010, 3'b100, 3'b000, 3'd0);
    check("delay_prevprev1", pm_II, 10'd50);

    // Sum and wrap
    do_reset();
    cyc(1, 14'sd8191, 0, 0, 4'b0, 3'b0, 3'b0, 3'd0);
    cyc(1, -14'sd300, 0, 0, 4'b0, 3'b0, 3'b0, 3'd0);
    idle(10);
    cyc(1, 14'sd8191, 0, 0, 4'b0, 3'b0, 3'b0, 3'd0);
    cyc(1, 14'sd100, 0, 0, 4'b0, 3'b0, 3'b0, 3'd0);
    idle(4);
    cyc(1, 0, 0, 0, 4'b0010, 3'b100, 3'b100, 3'd0);
    check("sum_wrap", pm_II, 10'h3FF);
    cyc(1, 0, 0, 0, 4'b1000, 3'b100, 3'b100, 3'd0);
    check("sum_neg", pm_II, 10'h39C);

    // S1 feedback on channel 0
    do_reset();
    cyc(1, 14'sd1000, 1, 0, 4'b0, 3'b0, 3'b0, 3'd0);
    idle(5);
    cyc(1, 14'sd600, 1, 0, 4'b0, 3'b0, 3'b0, 3'd0);
    idle(5);
    cyc(1, 0, 0, 0, 4'b0001, 3'b111, 3'b111, 3'd7);
    check("fb_7", pm_II, 10'd200);
    idle(5);
    cyc(1, 0, 0, 0, 4'b0001, 3'b000, 3'b000, 3'd0);
    check("fb_0", pm_II, 10'd0);
    idle(5);
    cyc(1, 0, 0, 0, 4'b0001, 3'b000, 3'b000, 3'd1);
    check("fb_1", pm_II, 10'd3);

    // Internal stores on channel 2
    do_reset();
    idle(2);
    cyc(1, 14'sd512, 1, 0, 4'b0, 3'b0, 3'b0, 3'd0);
    idle(5);
    cyc(1, -14'sd256, 0, 1, 4'b0, 3'b0, 3'b0, 3'd0);
    idle(5);
    cyc(1, 0, 0, 0, 4'b1000, 3'b001, 3'b001, 3'd0);
    check("internal_ch2", pm_II, 10'd128);
    cyc(1, 0, 0, 0, 4'b1000, 3'b001, 3'b001, 3'd0);
    check("internal_ch3", pm_II, 10'd0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] sl;
      logic signed [13:0] op;
      if ($urandom_range(0, 99) == 0) do_reset();
      else begin
        sl = 4'b0001 << $urandom_range(0, 3);
        if ($urandom_range(0, 4) == 0) sl = 4'b0;
        case ($urandom_range(0, 5))
          0: op = 14'sd8191;
          1: op = -14'sd8192;
          default: op = 14'($urandom);
        endcase
        cyc($urandom_range(0, 6) != 0, op, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            sl, pick_flags(), pick_flags(), 3'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
